alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU with valid/ready handshakes on input and output.
//   Keeps the opcodes 0-8 of the existing 32-bit combinational ALU and adds iterative MUL/DIVU/REMU plus status flags.
//   Sits between the operand-issue stage and the writeback stage of the datapath.
//   Single-cycle ops complete in 1 cycle; iterative ops take WIDTH cycles.
// PARAMETERS
//   WIDTH   32              operand/result width in bits (>=4)
//   SHW     $clog2(WIDTH)   shift-amount width (derived; not overridden)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operand/opcode valid
//   in_ready   out  1      block can accept an operation
//   in1        in   WIDTH  operand A (signed)
//   in2        in   WIDTH  operand B (signed)
//   opCode     in   4      operation select
//   shiftAmt   in   SHW    shift amount for opCode 4-6
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      downstream accepts result
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   ovf        out  1      signed overflow (ADD/SUB only, else 0)
//   div_zero   out  1      DIVU/REMU with in2 == 0
//   illegal    out  1      opCode 12-15 was issued
// BEHAVIOUR
//   Opcodes (result):
//     0 ADD a+b.
//     1 SUB a-b.
//     2 AND.
//     3 OR.
//     4 SLL a<<sh.
//     5 SRL logical.
//     6 SRA arithmetic.
//     7 SGT: 1 if a>b (signed), else 0.
//     8 SLT: 1 if a<b (signed), else 0.
//     9 MUL: low WIDTH bits of a*b (two's complement).
//     10 DIVU: unsigned a/b.
//     11 REMU: unsigned a%b.
//     12-15: result 0, illegal=1.
//   All arithmetic wraps modulo 2^WIDTH.
//   ovf on ADD: operand signs equal and differ from result sign.
//   ovf on SUB: operand signs differ and result sign != sign of a.
//   FSM states IDLE, BUSY, DONE. Reset state is IDLE.
//   in_ready = (state==IDLE) && !rst. Handshake fires when in_valid && in_ready; operands are captured on that edge.
//   IDLE transitions:
//     ops 0-8 and 12-15 -> DONE next cycle. out_valid rises 1 cycle after accept.
//     ops 9-11 -> BUSY. An iteration counter loads WIDTH-1.
//   BUSY:
//     MUL: shift-add, one bit per cycle.
//     DIVU/REMU: restoring division, one bit per cycle.
//     Counter reaching 0 -> DONE. out_valid rises WIDTH+1 cycles after accept.
//   DIVU/REMU with in2==0: skip BUSY and go -> DONE after 1 cycle. DIVU returns all-ones; REMU returns in1; div_zero=1.
//   DONE: out_valid=1. result and flags are held stable until out_ready.
//     out_ready high -> IDLE on the same edge.
//     No new op is accepted in DONE, so minimum issue interval is 2 cycles.
//   out_ready is ignored in IDLE and BUSY.
//   in_valid and input changes are ignored outside IDLE.
//   zero, ovf, div_zero and illegal update together with result. Each is 0 unless set by the current op.
//   Reset at any time, including mid-BUSY or in DONE, does all of the following immediately:
//     state=IDLE; out_valid=0; result=0; all flags=0; counter=0; partial products cleared.
//     The in-flight op is discarded and never reported.
//   Shift by 0 returns a unchanged. SRA of a negative value fills with 1s.
// TESTING
//   (WIDTH=32)
//   1 ADD 5+7, out_ready=1 -> out_valid 1 cycle after accept, result=12, zero=0.
//     ADD 0x7FFFFFFF+1 -> result=0x80000000, ovf=1.
//   2 SUB -5-(-5) -> 0, zero=1.
//     SRA -16 by 1 -> -8.
//     SRL -16 by 1 -> 0x7FFFFFF8.
//     SGT -16,7 -> 0.
//     SLT -16,7 -> 1.
//   3 MUL -3*7 -> 0xFFFFFFEB after exactly 33 cycles.
//     in_ready is low throughout BUSY and DONE.
//   4 DIVU 100/7 -> 14; REMU 100%7 -> 2.
//     DIVU 9/0 -> 0xFFFFFFFF with div_zero=1, 1-cycle latency.
//   5 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored.
//     Release -> in_ready=1 on the next cycle.
//   6 Assert rst at BUSY cycle 10 of a MUL -> out_valid=0 and result=0 immediately.
//     After deassert, ADD 1+1 -> 2 with normal latency.
//     opCode 13 -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_seq_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if
//   Handshake bundle between the operand-issue stage (master) and the
//   sequential ALU (slave).
//
//   Issue side : in_valid / in_ready, in1, in2, opCode, shiftAmt
//   Result side: out_valid / out_ready, result, zero, ovf, div_zero, illegal
//
//   master : drives operands and out_ready, observes readiness and results
//   slave  : the ALU, the mirror image of master
// ----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [3:0]         opCode;
    logic [SHW-1:0]     shiftAmt;

    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               ovf;
    logic               div_zero;
    logic               illegal;

    modport master (
        output in_valid, in1, in2, opCode, shiftAmt, out_ready,
        input  in_ready, out_valid, result, zero, ovf, div_zero, illegal
    );

    modport slave (
        input  in_valid, in1, in2, opCode, shiftAmt, out_ready,
        output in_ready, out_valid, result, zero, ovf, div_zero, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
//   Registered ALU with valid/ready handshakes on both sides. Opcodes 0-8 and
//   the illegal range 12-15 complete one cycle after acceptance; MUL, DIVU and
//   REMU iterate one bit per cycle and complete WIDTH+1 cycles after
//   acceptance. A divide by zero short-cuts to the one-cycle path.
//
// Ports
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high reset
//   bus   alu_seq_if.slave
//         in_valid/in_ready   operation handshake (in_ready only in IDLE)
//         in1, in2            operands A and B
//         opCode, shiftAmt    operation select and shift amount
//         out_valid/out_ready result handshake (result held until taken)
//         result, zero, ovf, div_zero, illegal   registered result and flags
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    // WIDTH-1 always fits in SHW bits, so the counter needs no extra bit.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_SGT  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;

    // Iteration datapath. r_x/r_y are reused between the two algorithms:
    //   MUL : r_acc partial product, r_x multiplier (shifts right),
    //         r_y multiplicand (shifts left)
    //   DIV : r_acc partial remainder, r_x dividend shifting out / quotient
    //         shifting in, r_y divisor
    logic [3:0]         r_op;
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_div_zero;
    logic               r_illegal;

    logic               w_accept;
    logic               w_is_div;
    logic               w_div_by_zero;
    logic               w_iterative;
    logic               w_load_fast;
    logic               w_load_iter;
    logic               w_finish;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_fast_result;
    logic               w_fast_ovf;

    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_iter_result;

    // ------------------------------------------------------------------------
    // Handshake and operation classification
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign bus.div_zero  = r_div_zero;
    assign bus.illegal   = r_illegal;

    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_is_div      = (bus.opCode == OP_DIVU) || (bus.opCode == OP_REMU);
    assign w_div_by_zero = w_is_div && (bus.in2 == '0);
    assign w_iterative   = (bus.opCode == OP_MUL) || (w_is_div && !w_div_by_zero);

    // ------------------------------------------------------------------------
    // Single-cycle result, computed straight from the accepted operands
    // ------------------------------------------------------------------------
    assign w_sum  = bus.in1 + bus.in2;
    assign w_diff = bus.in1 - bus.in2;

    always_comb begin
        // NOTE: every signal driven in always_comb gets a default first, so no
        // path through the case can leave it unassigned and infer a latch.
        w_fast_result = '0;
        w_fast_ovf    = 1'b0;
        case (bus.opCode)
            OP_ADD: begin
                w_fast_result = w_sum;
                w_fast_ovf    = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_fast_result = w_diff;
                w_fast_ovf    = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_AND:  w_fast_result = bus.in1 & bus.in2;
            OP_OR:   w_fast_result = bus.in1 | bus.in2;
            OP_SLL:  w_fast_result = bus.in1 << bus.shiftAmt;
            OP_SRL:  w_fast_result = bus.in1 >> bus.shiftAmt;
            OP_SRA:  w_fast_result = $signed(bus.in1) >>> bus.shiftAmt;
            OP_SGT:  w_fast_result = {{(WIDTH-1){1'b0}},
                                      $signed(bus.in1) > $signed(bus.in2)};
            OP_SLT:  w_fast_result = {{(WIDTH-1){1'b0}},
                                      $signed(bus.in1) < $signed(bus.in2)};
            // Only reached on the fast path when the divisor is zero.
            OP_DIVU: w_fast_result = '1;
            OP_REMU: w_fast_result = bus.in1;
            default: w_fast_result = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------------
    assign w_mul_acc = r_acc + (r_x[0] ? r_y : '0);

    // Shift the next dividend bit into the remainder and try the subtract;
    // a clear borrow bit means the divisor fits.
    assign w_trial    = {r_acc, r_x[WIDTH-1]} - {1'b0, r_y};
    assign w_fits     = !w_trial[WIDTH];
    assign w_rem_next = w_fits ? w_trial[WIDTH-1:0] : {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
    assign w_quo_next = {r_x[WIDTH-2:0], w_fits};

    always_comb begin
        w_iter_result = w_mul_acc;
        if (r_op == OP_DIVU) begin
            w_iter_result = w_quo_next;
        end else if (r_op == OP_REMU) begin
            w_iter_result = w_rem_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and datapath strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_fast  = 1'b0;
        w_load_iter  = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_iterative) begin
                        w_load_iter  = 1'b1;
                        w_state_next = BUSY;
                    end else begin
                        w_load_fast  = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            BUSY: begin
                // The last iteration and the result write share this edge.
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the datapath is cleared on reset as well as the state, so an
        // aborted operation leaves no partial product or stale result behind.
        if (rst) begin
            r_op       <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_div_zero <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register updates
            // from the values present before the edge regardless of order.
            if (w_load_iter) begin
                r_op  <= bus.opCode;
                r_cnt <= CNT_LAST;
                r_acc <= '0;
                if (bus.opCode == OP_MUL) begin
                    r_x <= bus.in2;
                    r_y <= bus.in1;
                end else begin
                    r_x <= bus.in1;
                    r_y <= bus.in2;
                end
            end else if (r_state == BUSY) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (r_op == OP_MUL) begin
                    r_acc <= w_mul_acc;
                    r_x   <= r_x >> 1;
                    r_y   <= r_y << 1;
                end else begin
                    r_acc <= w_rem_next;
                    r_x   <= w_quo_next;
                end
            end

            if (w_load_fast) begin
                r_result   <= w_fast_result;
                r_zero     <= (w_fast_result == '0);
                r_ovf      <= w_fast_ovf;
                r_div_zero <= w_div_by_zero;
                r_illegal  <= (bus.opCode > OP_REMU);
            end else if (w_finish) begin
                r_result   <= w_iter_result;
                r_zero     <= (w_iter_result == '0);
                r_ovf      <= 1'b0;
                r_div_zero <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
//   Scoreboard bench for alu_seq (WIDTH = 32). The driver pushes the expected
//   response for each accepted operation; a monitor on the falling edge pops
//   and compares on every result handshake, also checking latency, in_ready
//   and that result/flags stay stable while out_valid is held.
// ----------------------------------------------------------------------------
module tb_alu_seq;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         dz;
        logic         il;
        int           lat;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   bp_mode = 0;     // 0: always ready, 1: random, 2: stalled
    bit   outstanding = 1'b0;
    bit   prev_valid = 1'b0;
    int   rise_cyc = 0;
    logic [W+3:0] held;
    exp_t exp_q[$];

    alu_seq_if #(.WIDTH(W)) dut_if ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the opcode table, using 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sa;
        longint sb;
        longint s;
        logic [W-1:0] r32;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = '0; e.o = 1'b0; e.dz = 1'b0; e.il = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            4'd0: begin s = sa + sb; r32 = s[W-1:0]; e.res = r32;
                        e.o = (s != longint'($signed(r32))); end
            4'd1: begin s = sa - sb; r32 = s[W-1:0]; e.res = r32;
                        e.o = (s != longint'($signed(r32))); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a << sh;
            4'd5: e.res = a >> sh;
            4'd6: e.res = W'($signed(a) >>> sh);
            4'd7: e.res = (sa > sb) ? 32'd1 : 32'd0;
            4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: begin s = sa * sb; e.res = s[W-1:0]; e.lat = W + 1; end
            4'd10: begin
                e.dz  = (b == 0);
                e.res = e.dz ? 32'hFFFF_FFFF : a / b;
                e.lat = e.dz ? 1 : W + 1;
            end
            4'd11: begin
                e.dz  = (b == 0);
                e.res = e.dz ? a : a % b;
                e.lat = e.dz ? 1 : W + 1;
            end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Present one operation; while the DUT is not ready, drive junk (possibly
    // with in_valid high) that it must ignore.
    task automatic issue_raw(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [4:0] sh, input exp_t e);
        int waited = 0;
        @(negedge clk);
        while (!dut_if.in_ready && waited < 300) begin
            dut_if.in_valid = 1'($urandom_range(0, 1));
            dut_if.opCode   = 4'($urandom);
            dut_if.in1      = $urandom;
            dut_if.in2      = $urandom;
            dut_if.shiftAmt = 5'($urandom);
            waited++;
            @(negedge clk);
        end
        if (!dut_if.in_ready) begin
            check("issue_ready_timeout", {63'd0, dut_if.in_ready}, 64'd1);
            dut_if.in_valid = 1'b0;
            return;
        end
        dut_if.in_valid = 1'b1;
        dut_if.opCode   = op;
        dut_if.in1      = a;
        dut_if.in2      = b;
        dut_if.shiftAmt = sh;
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
        outstanding     = 1'b1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
        issue_raw(op, a, b, sh, model(op, a, b, sh));
    endtask

    task automatic issue_k(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sh, input logic [W-1:0] res, input logic z,
                           input logic o, input logic dz, input logic il, input int lat);
        exp_t e;
        e.res = res; e.z = z; e.o = o; e.dz = dz; e.il = il; e.lat = lat; e.acc = 0;
        issue_raw(op, a, b, sh, e);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", {63'd0, dut_if.in_ready}, {63'd0, !outstanding});
        end
        case (bp_mode)
            0:       dut_if.out_ready = 1'b1;
            1:       dut_if.out_ready = 1'($urandom_range(0, 1));
            default: dut_if.out_ready = 1'b0;
        endcase
        if (dut_if.out_valid && !prev_valid) begin
            rise_cyc = cyc;
            held = {dut_if.result, dut_if.zero, dut_if.ovf, dut_if.div_zero, dut_if.illegal};
        end else if (dut_if.out_valid) begin
            check("hold_stable",
                  64'({dut_if.result, dut_if.zero, dut_if.ovf, dut_if.div_zero, dut_if.illegal}),
                  64'(held));
        end
        if (dut_if.out_valid && dut_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {63'd0, dut_if.out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",   64'(dut_if.result),   64'(e.res));
                check("zero",     64'(dut_if.zero),     64'(e.z));
                check("ovf",      64'(dut_if.ovf),      64'(e.o));
                check("div_zero", 64'(dut_if.div_zero), 64'(e.dz));
                check("illegal",  64'(dut_if.illegal),  64'(e.il));
                check("latency",  64'(rise_cyc - e.acc), 64'(e.lat));
            end
            outstanding = 1'b0;
        end
        prev_valid = dut_if.out_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        dut_if.in_valid  = 1'b0;
        dut_if.in1       = '0;
        dut_if.in2       = '0;
        dut_if.opCode    = '0;
        dut_if.shiftAmt  = '0;
        dut_if.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(dut_if.in_ready),  64'd0);
        check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("rst_result",    64'(dut_if.result),    64'd0);
        check("rst_flags", 64'({dut_if.zero, dut_if.ovf, dut_if.div_zero, dut_if.illegal}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(dut_if.in_ready), 64'd1);

        // Single-cycle ops and flags
        issue_k(4'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue_k(4'd1, -32'sd5, -32'sd5, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd6, -32'sd16, 32'd0, 5'd1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd5, -32'sd16, 32'd0, 5'd1, 32'h7FFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd7, -32'sd16, 32'd7, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd8, -32'sd16, 32'd7, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd4, 32'hDEAD_BEEF, 32'd0, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1);

        // Iterative ops and divide by zero
        issue_k(4'd9, -32'sd3, 32'd7, 5'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0, 1'b0, 33);
        issue_k(4'd10, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 33);
        issue_k(4'd11, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33);
        issue_k(4'd10, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue_k(4'd11, 32'd9, 32'd0, 5'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        drain();

        // Back-pressure in DONE with in_valid pushed at a non-ready DUT
        bp_mode = 2;
        issue_k(4'd0, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        waited = 0;
        while (!dut_if.out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dut_if.in_valid = 1'b1;
            dut_if.opCode   = 4'd0;
            dut_if.in1      = $urandom;
            check("stall_in_ready",  64'(dut_if.in_ready),  64'd0);
            check("stall_out_valid", 64'(dut_if.out_valid), 64'd1);
            check("stall_result",    64'(dut_if.result),    64'd7);
        end
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
        bp_mode = 0;
        drain();

        // Reset in the middle of a multiply
        issue(4'd9, pick(), pick(), 5'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        outstanding = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("midrst_result",    64'(dut_if.result),    64'd0);
        check("midrst_in_ready",  64'(dut_if.in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("aborted_op_result", 64'(dut_if.result), 64'd0);
        issue_k(4'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue_k(4'd13, $urandom, $urandom, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        drain();

        // Randomised traffic with random back-pressure
        bp_mode = 1;
        for (int n = 0; n < 400; n++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
